// File: rtl/hs_ctrl_pkg.sv
// Shared types and constants for the join/delay/fork handshake controller.
package hs_ctrl_pkg;

  localparam int unsigned MAX_CHAN    = 8;
  localparam int unsigned DEF_DELAY_W = 8;
  localparam int unsigned DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StReq,
    StRtz
  } hs_state_e;

endpackage

// File: rtl/hs_delay_counter.sv
// Programmable matched-delay down-counter: load on IDLE exit, signal done at count 1.
module hs_delay_counter #(
  parameter int unsigned DELAY_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [DELAY_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               done_o
);

  logic [DELAY_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DELAY_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == DELAY_W'(1));

endmodule

// File: rtl/hs_join_fork_ctrl.sv
// N-input join, programmable matched delay and M-output fork with 4-phase handshakes,
// sticky protocol-error flag and a completed-token counter.
module hs_join_fork_ctrl
  import hs_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IN  = 3,
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned DELAY_W = DEF_DELAY_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [DELAY_W-1:0] delay_i,
  input  logic [NUM_IN-1:0]  req_in_i,
  output logic [NUM_IN-1:0]  ack_in_o,
  output logic [NUM_OUT-1:0] req_out_o,
  input  logic [NUM_OUT-1:0] ack_out_i,
  output logic               busy_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   tok_cnt_o
);

  if (NUM_IN < 1 || NUM_IN > MAX_CHAN || NUM_OUT < 1 || NUM_OUT > MAX_CHAN) begin : gen_bad_chan
    $error("hs_join_fork_ctrl: NUM_IN/NUM_OUT out of range");
  end

  hs_state_e          state_d, state_q;
  logic [NUM_IN-1:0]  ack_in_d, ack_in_q;
  logic [NUM_IN-1:0]  req_in_q;
  logic [NUM_OUT-1:0] ack_seen_d, ack_seen_q;
  logic [NUM_OUT-1:0] ack_out_q;
  logic [CNT_W-1:0]   tok_d, tok_q;
  logic               err_d, err_q;
  logic               join_ok, enter_req, cnt_load, cnt_dec, cnt_done;
  logic               err_ack_fall, err_ack_early, err_req_early;

  // A start_i token counts as a complete join; both at once still make one token.
  assign join_ok = ((&req_in_i) | start_i) & ~(|ack_in_q);

  always_comb begin
    state_d    = state_q;
    ack_seen_d = ack_seen_q;
    tok_d      = tok_q;
    enter_req  = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (join_ok) begin
          cnt_load = 1'b1;
          if (delay_i == '0) begin
            state_d   = StReq;
            enter_req = 1'b1;
          end else begin
            state_d = StDelay;
          end
        end
      end
      StDelay: begin
        cnt_dec = 1'b1;
        if (cnt_done) begin
          state_d   = StReq;
          enter_req = 1'b1;
        end
      end
      StReq: begin
        ack_seen_d = ack_seen_q | ack_out_i;
        if (&ack_seen_d) begin
          state_d = StRtz;
        end
      end
      StRtz: begin
        if (ack_out_i == '0) begin
          state_d = StIdle;
          tok_d   = tok_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (enter_req) begin
      ack_seen_d = '0;
    end
  end

  // Input acks rise only for requests still high at REQ entry, then release bit by bit.
  assign ack_in_d = (enter_req ? {NUM_IN{1'b1}} : ack_in_q) & req_in_i;

  assign err_ack_fall  = (state_q == StReq) & (|(ack_seen_q & ack_out_q & ~ack_out_i));
  assign err_ack_early = ((state_q == StIdle) | (state_q == StDelay)) & (|ack_out_i);
  assign err_req_early = (state_q == StDelay) & (|(req_in_q & ~req_in_i));
  assign err_d         = err_q | err_ack_fall | err_ack_early | err_req_early;

  hs_delay_counter #(
    .DELAY_W(DELAY_W)
  ) u_delay_counter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (cnt_load),
    .load_val_i(delay_i),
    .dec_i     (cnt_dec),
    .done_o    (cnt_done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      ack_in_q   <= '0;
      req_in_q   <= '0;
      ack_seen_q <= '0;
      ack_out_q  <= '0;
      tok_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_in_q   <= ack_in_d;
      req_in_q   <= req_in_i;
      ack_seen_q <= ack_seen_d;
      ack_out_q  <= ack_out_i;
      tok_q      <= tok_d;
      err_q      <= err_d;
    end
  end

  assign req_out_o = {NUM_OUT{state_q == StReq}};
  assign ack_in_o  = ack_in_q;
  assign busy_o    = (state_q != StIdle);
  assign err_o     = err_q;
  assign tok_cnt_o = tok_q;

endmodule

// File: doc/hs_join_fork_ctrl.md
Name: hs_join_fork_ctrl

Overview:
Clocked, parametrised 4-phase handshake controller for the asynchronous-Ibex control network. It combines three functions in one element:
- an N-input join;
- a programmable matched-delay stage, which replaces the fixed DELAY defparam with a runtime value;
- an M-output fork.

It adds protocol-error detection, a start injection input and a completed-token counter. It sits wherever a join→controller→fork chain is needed (e.g. the issue and ALU stages), and lets benches sweep stage delays without re-elaboration.

Parameters:
- NUM_IN, 3, number of joined request/ack input channels (1..8)
- NUM_OUT, 4, number of forked request/ack output channels (1..8)
- DELAY_W, 8, width of the matched-delay counter
- CNT_W, 16, width of the completed-token counter

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  token injection; acts as a full join in IDLE (replaces OR'd req_start)
- delay_i  in  DELAY_W  matched delay in cycles, sampled on IDLE exit
- req_in_i  in  NUM_IN  input requests
- ack_in_o  out  NUM_IN  input acknowledges
- req_out_o  out  NUM_OUT  output requests
- ack_out_i  in  NUM_OUT  output acknowledges
- busy_o  out  1  high in any state other than IDLE
- err_o  out  1  sticky protocol error
- tok_cnt_o  out  CNT_W  completed handshakes, wraps modulo 2^CNT_W

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; req_out_o=0, ack_in_o=0, busy_o=0, err_o=0, tok_cnt_o=0, delay counter=0.
- All inputs are treated as synchronous to clk_i; no internal synchronisers.
- FSM states: IDLE, DELAY, REQ, RTZ.
- IDLE:
  - Leave when (&req_in_i or start_i) and ack_in_o==0.
  - On exit, load cnt=delay_i.
  - If delay_i==0, go to REQ; else go to DELAY.
- DELAY: cnt decrements each cycle; at cnt==1 go to REQ. Total latency from join to req_out_o high = max(delay_i,0)+1 cycles.
- REQ (entry):
  - req_out_o = all ones.
  - ack_in_o = all ones, except bits whose req_in_i is already low (start_i-injected tokens).
  - Clear the ack_seen vector.
- REQ (per cycle):
  - ack_seen |= ack_out_i.
  - ack_in_o[i] clears the cycle after req_in_i[i] is seen low. This is per-bit and independent of the other channels.
  - Go to RTZ when &ack_seen.
- RTZ:
  - req_out_o = 0.
  - Per-bit ack_in_o release continues.
  - Go to IDLE when ack_out_i==0; tok_cnt_o increments on that transition.
- ack_in_o bits still high on IDLE entry keep releasing per-bit. A new join is blocked until ack_in_o==0.
- Protocol errors set err_o, which is cleared only by reset:
  - ack_out_i[j] falls while req_out_o[j]=1 and ack_seen[j]=1;
  - ack_out_i[j] high in IDLE or DELAY;
  - req_in_i[i] falls in DELAY, i.e. before ack_in_o[i] rises. In this case the FSM still proceeds.
- Simultaneous start_i and &req_in_i: a single token only.
- start_i in a state other than IDLE is ignored.
- delay_i changes after the IDLE exit have no effect on the current token.
- tok_cnt_o wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-handshake: all outputs drop immediately (async). The environment must re-initialise its own channels.

Decomposition:
- Package hs_ctrl_pkg: state enum (IDLE/DELAY/REQ/RTZ), MAX_CHAN=8 constant, default DELAY_W/CNT_W.
- One sub-module, hs_delay_counter: load/decrement/done, parametrised by DELAY_W.
- Join reduction, ack_seen and error logic stay in the top module.

Test Plan:
1. NUM_IN=3, NUM_OUT=4, delay_i=5, all req_in_i rise together → req_out_o=4'hF exactly 6 cycles later, ack_in_o=3'b111 in the same cycle. Full return-to-zero → tok_cnt_o=1, busy_o=0.
2. delay_i=0, req_in_i bits rise on cycles 0/3/7 → no join until cycle 7, req_out_o high at cycle 8. Output acks arrive staggered over 10 cycles → RTZ only after the last ack.
3. start_i pulse with req_in_i=0, delay_i=2 → req_out_o high 3 cycles later, ack_in_o stays 0, err_o=0.
4. ack_out_i[2] raised then dropped while in REQ → err_o=1 and stays 1. A second token still completes, tok_cnt_o=2.
5. CNT_W=4, 17 back-to-back tokens → tok_cnt_o=1. Also check ack_in_o release order is per-bit when req_in_i fall on different cycles.
6. rst_ni pulsed low in DELAY and in REQ → all outputs 0 in the same cycle, next token behaves as in scenario 1.
